board_io_bank: RTL and testbench
================================

# board_io_bank

Parametrised N-channel board I/O controller that sits between the processor-side GPIO/peripheral logic and the top-level IOBUF primitives in the board wrapper. For each channel it drives the IOBUF I/T pins according to a per-channel mode: input, push-pull or open-drain. It also synchronises and debounces the pad input, detects masked rising and falling edges into sticky status bits, and raises a single interrupt. It generalises the fixed per-signal IOBUF hookup used for I2C, MDIO, SPI, buttons and switches.

## Interface
Parameters:
- NUM_CH, 8, number of channels (1..32)
- CNT_W, 16, debounce counter width
- FILTER_CYCLES, 1000, consecutive cycles a new synchronised level must persist before it is accepted (1..2^CNT_W-1)

Ports:
- sys_clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- pad_i  in  NUM_CH  raw pad level from IOBUF O
- pad_o  out  NUM_CH  to IOBUF I
- pad_t  out  NUM_CH  to IOBUF T; 1 = high-Z
- mode  in  2*NUM_CH  bits [2c+1:2c] for channel c: 00 input, 01 push-pull, 10 open-drain, 11 treated as input
- out_data  in  NUM_CH  requested output level
- in_data  out  NUM_CH  filtered input level
- rise_mask  in  NUM_CH  enable rising-edge capture
- fall_mask  in  NUM_CH  enable falling-edge capture
- irq_clr  in  NUM_CH  write-1-to-clear pulse per status bit
- irq_status  out  NUM_CH  sticky edge-event bits
- irq  out  1  OR of irq_status

## Operation
- **Drive path**, registered, per channel:
  - input/reserved: pad_t=1, pad_o=0.
  - push-pull: pad_t=0, pad_o=out_data.
  - open-drain: pad_o=0, pad_t=out_data, so 1 releases the line and 0 pulls it low.
- **Input path**: pad_i → 2-flop synchroniser (sync1, sync2) → debounce → stable register → in_data.
- **Debounce**, per channel: counter cnt[CNT_W-1:0].
  - sync2==stable: cnt<=0.
  - sync2!=stable and cnt==FILTER_CYCLES-1: stable<=sync2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any return to the stable level before acceptance restarts the count. No wrap is possible because the FILTER_CYCLES-1 limit is below the counter maximum.
- **Edge detect**: rise = stable updates 0→1; fall = stable updates 1→0.
  - irq_status[c] sets on (rise & rise_mask[c]) | (fall & fall_mask[c]).
  - irq_status[c] clears on irq_clr[c].
  - Set and clear in the same cycle: set wins.
  - Masks gate capture only; they do not clear existing status.
- irq = |irq_status, combinational from registers.
- Mode changes take effect on the next drive-register update. The input path runs regardless of mode, so open-drain readback works; this is the I2C/MDIO case.
- **Reset**, asynchronous and immediate:
  - pad_t all 1, pad_o 0.
  - sync1, sync2, stable and in_data 0.
  - cnt 0, irq_status 0, irq 0.
  - Reset mid-filter discards the partial count.
  - A pad held high through reset produces a rise event FILTER_CYCLES+2 edges after reset deasserts, if rise_mask is set.

## Timing
- Drive: pad_o/pad_t reflect mode/out_data one sys_clock edge after they are sampled.
- Input: a pad_i change sampled at edge k appears on sync2 after edge k+1 and on in_data after edge k+1+FILTER_CYCLES.
- Total latency is FILTER_CYCLES+2 edges.
- irq_status and irq update on the same edge as in_data.
- irq_clr takes effect on the next edge; irq drops in the same cycle status clears.

## Configuration
- Macro: BOARD_IO_BANK_DEBOUNCE_EN.
- Defined: the debounce filter is implemented as above.
- Undefined:
  - Counters are removed and FILTER_CYCLES/CNT_W are ignored.
  - stable<=sync2 every cycle, so in_data latency is 2 edges plus 1 register (3 edges total).
  - Edge detection and the drive path are unchanged.

## Test plan
Bench configuration: NUM_CH=4, FILTER_CYCLES=4, macro defined unless stated.

- **Reset values**: assert reset mid-run with pad_i=4'hF → pad_t=4'hF, pad_o=0, irq_status=0, irq=0 immediately. After release with rise_mask=4'hF, in_data=4'hF and irq_status=4'hF exactly 6 edges later.
- **Drive modes**: mode={11,10,01,00}, out_data=4'b0110 → next edge pad_t=4'b1101, pad_o=4'b0010. Then out_data=4'b0000 → pad_t=4'b1001 (open-drain ch2 pulls low).
- **Glitch rejection**: ch0 high for 3 cycles, then low → in_data[0] stays 0, no irq. High for 4 cycles → in_data[0]=1 at edge k+5 and irq_status[0]=1 if rise_mask[0]=1.
- **Masking and falling edge**: rise_mask=0, fall_mask[1]=1; ch1 pulse 10 cycles → no status on rise, irq_status[1] set 6 edges after the falling pad edge.
- **Set/clear collision**: irq_clr[2]=1 on the same edge a masked rise on ch2 is accepted → irq_status[2]=1. irq_clr[2] on the next edge → 0, irq=0.
- **Macro undefined**: ch3 1-cycle pulse → in_data[3] follows with 3-edge latency; a rise event is captured.

Source files
------------

// File: rtl/board_io_bank.sv
// N-channel board I/O bank: IOBUF drive modes, synchronised/debounced input, masked edge IRQ.
// Define BOARD_IO_BANK_DEBOUNCE_EN to build the per-channel debounce filter.
module board_io_bank #(
  parameter int NUM_CH        = 8,
  parameter int CNT_W         = 16,
  parameter int FILTER_CYCLES = 1000
) (
  input  logic                sys_clock,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   pad_i,
  output logic [NUM_CH-1:0]   pad_o,
  output logic [NUM_CH-1:0]   pad_t,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   out_data,
  output logic [NUM_CH-1:0]   in_data,
  input  logic [NUM_CH-1:0]   rise_mask,
  input  logic [NUM_CH-1:0]   fall_mask,
  input  logic [NUM_CH-1:0]   irq_clr,
  output logic [NUM_CH-1:0]   irq_status,
  output logic                irq
);

  if (NUM_CH < 1 || NUM_CH > 32 || FILTER_CYCLES < 1 ||
      FILTER_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("board_io_bank: parameter out of range");
  end

  logic [NUM_CH-1:0] r_pad_o;
  logic [NUM_CH-1:0] r_pad_t;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_stable;
  logic [NUM_CH-1:0] r_status;
  logic [NUM_CH-1:0] w_drv_o;
  logic [NUM_CH-1:0] w_drv_t;
  logic [NUM_CH-1:0] w_next_stable;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_set;

  // Open-drain only ever drives 0; out_data=1 releases the line via T.
  always_comb begin
    w_drv_o = '0;
    w_drv_t = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      unique case (mode[2*c +: 2])
        2'b01: begin
          w_drv_o[c] = out_data[c];
          w_drv_t[c] = 1'b0;
        end
        2'b10: begin
          w_drv_o[c] = 1'b0;
          w_drv_t[c] = out_data[c];
        end
        default: begin
          w_drv_o[c] = 1'b0;
          w_drv_t[c] = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_pad_o <= '0;
      r_pad_t <= '1;
    end else begin
      r_pad_o <= w_drv_o;
      r_pad_t <= w_drv_t;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BOARD_IO_BANK_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FILTER_CYCLES - 1);

  logic [NUM_CH-1:0] w_accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;

    assign w_accept[c] = (r_sync2[c] != r_stable[c]) && (r_cnt == LIMIT);

    // Any return to the stable level restarts the count.
    always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if ((r_sync2[c] == r_stable[c]) || w_accept[c]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_next_stable = (r_stable & ~w_accept) | (r_sync2 & w_accept);
`else
  assign w_next_stable = r_sync2;
`endif

  assign w_rise = w_next_stable & ~r_stable;
  assign w_fall = ~w_next_stable & r_stable;
  assign w_set  = (w_rise & rise_mask) | (w_fall & fall_mask);

  // Set has priority over a same-cycle clear.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      r_status <= '0;
    end else begin
      r_stable <= w_next_stable;
      r_status <= w_set | (r_status & ~irq_clr);
    end
  end

  assign pad_o      = r_pad_o;
  assign pad_t      = r_pad_t;
  assign in_data    = r_stable;
  assign irq_status = r_status;
  assign irq        = |r_status;

endmodule

// File: tb/tb_board_io_bank.sv
// Directed self-checking bench for board_io_bank (NUM_CH=4, FILTER_CYCLES=4).
// Expected latencies follow BOARD_IO_BANK_DEBOUNCE_EN when it is defined globally.
module tb_board_io_bank;

  localparam int NCH = 4;
  localparam int FC  = 4;
`ifdef BOARD_IO_BANK_DEBOUNCE_EN
  localparam int LAT = FC + 2;
`else
  localparam int LAT = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] pad_i;
  logic [NCH-1:0] pad_o;
  logic [NCH-1:0] pad_t;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0] out_data;
  logic [NCH-1:0] in_data;
  logic [NCH-1:0] rise_mask;
  logic [NCH-1:0] fall_mask;
  logic [NCH-1:0] irq_clr;
  logic [NCH-1:0] irq_status;
  logic           irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  board_io_bank #(
    .NUM_CH(NCH),
    .CNT_W(16),
    .FILTER_CYCLES(FC)
  ) dut (
    .sys_clock (clk),
    .reset     (rst),
    .pad_i     (pad_i),
    .pad_o     (pad_o),
    .pad_t     (pad_t),
    .mode      (mode),
    .out_data  (out_data),
    .in_data   (in_data),
    .rise_mask (rise_mask),
    .fall_mask (fall_mask),
    .irq_clr   (irq_clr),
    .irq_status(irq_status),
    .irq       (irq)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    irq_clr = '1;
    step(1);
    irq_clr = '0;
  endtask

  task automatic test_reset();
    pad_i = '1;
    rise_mask = '1;
    fall_mask = '0;
    mode = 8'h55;
    out_data = 4'hA;
    step(3);
    vectors++;
    if (pad_t !== 4'h0) begin
      miscompares++;
      $display("FAIL pre_reset_pad_t got %h want %h", pad_t, 4'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (pad_t !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_pad_t got %h want %h", pad_t, 4'hF);
    end
    vectors++;
    if (pad_o !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_pad_o got %h want %h", pad_o, 4'h0);
    end
    vectors++;
    if (irq_status !== 4'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_irq got %h/%b want 0/0", irq_status, irq);
    end
    vectors++;
    if (in_data !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_in_data got %h want %h", in_data, 4'h0);
    end
    step(2);
    rst = 1'b0;
    step(LAT - 1);
    vectors++;
    if (in_data !== 4'h0 || irq_status !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_early got %h/%h want 0/0", in_data, irq_status);
    end
    step(1);
    vectors++;
    if (in_data !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_in_data_lat got %h want %h", in_data, 4'hF);
    end
    vectors++;
    if (irq_status !== 4'hF || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rise got %h/%b want F/1", irq_status, irq);
    end
    clear_all();
    vectors++;
    if (irq_status !== 4'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_all got %h/%b want 0/0", irq_status, irq);
    end
    rise_mask = '0;
    pad_i = '0;
    step(LAT + 2);
    vectors++;
    if (in_data !== 4'h0 || irq_status !== 4'h0) begin
      miscompares++;
      $display("FAIL settle got %h/%h want 0/0", in_data, irq_status);
    end
  endtask

  task automatic test_drive_modes();
    mode = 8'b11_10_01_00;
    out_data = 4'b0110;
    step(1);
    vectors++;
    if (pad_t !== 4'b1101) begin
      miscompares++;
      $display("FAIL drv_t got %b want %b", pad_t, 4'b1101);
    end
    vectors++;
    if (pad_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL drv_o got %b want %b", pad_o, 4'b0010);
    end
    out_data = 4'b0000;
    #1;
    vectors++;
    if (pad_t !== 4'b1101) begin
      miscompares++;
      $display("FAIL drv_hold got %b want %b", pad_t, 4'b1101);
    end
    step(1);
    vectors++;
    if (pad_t !== 4'b1001) begin
      miscompares++;
      $display("FAIL drv_od_low got %b want %b", pad_t, 4'b1001);
    end
    vectors++;
    if (pad_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL drv_o_zero got %b want %b", pad_o, 4'b0000);
    end
  endtask

  task automatic test_glitch();
    rise_mask = 4'b0001;
    pad_i[0] = 1'b1;
    step(3);
    pad_i[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      vectors++;
      if (in_data[0] !== 1'b0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_c%0d got %b/%b want 0/0", i, in_data[0], irq);
      end
    end
    pad_i[0] = 1'b1;
    step(4);
    pad_i[0] = 1'b0;
    step(1);
    vectors++;
    if (in_data[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_k4 got %b want 0", in_data[0]);
    end
    step(1);
    vectors++;
    if (in_data[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_k5 got %b want 1", in_data[0]);
    end
    vectors++;
    if (irq_status !== 4'b0001 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_irq got %b/%b want 0001/1", irq_status, irq);
    end
    rise_mask = '0;
    step(LAT + 2);
    clear_all();
  endtask

  task automatic test_fall_mask();
    rise_mask = '0;
    fall_mask = 4'b0010;
    pad_i[1] = 1'b1;
    step(10);
    vectors++;
    if (in_data[1] !== 1'b1 || irq_status !== 4'b0000) begin
      miscompares++;
      $display("FAIL fall_rise got %b/%b want 1/0000", in_data[1], irq_status);
    end
    pad_i[1] = 1'b0;
    step(LAT - 1);
    vectors++;
    if (in_data[1] !== 1'b1 || irq_status !== 4'b0000) begin
      miscompares++;
      $display("FAIL fall_early got %b/%b want 1/0000", in_data[1], irq_status);
    end
    step(1);
    vectors++;
    if (in_data[1] !== 1'b0 || irq_status !== 4'b0010 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL fall_set got %b/%b/%b want 0/0010/1",
               in_data[1], irq_status, irq);
    end
    fall_mask = '0;
    step(1);
    vectors++;
    if (irq_status !== 4'b0010) begin
      miscompares++;
      $display("FAIL mask_no_clear got %b want 0010", irq_status);
    end
    clear_all();
  endtask

  task automatic test_collision();
    rise_mask = 4'b0100;
    pad_i[2] = 1'b1;
    step(LAT - 1);
    irq_clr = 4'b0100;
    step(1);
    vectors++;
    if (irq_status !== 4'b0100 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_set got %b/%b want 0100/1", irq_status, irq);
    end
    step(1);
    vectors++;
    if (irq_status !== 4'b0000 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_clr got %b/%b want 0000/0", irq_status, irq);
    end
    irq_clr = '0;
    rise_mask = '0;
    pad_i[2] = 1'b0;
    step(LAT + 2);
  endtask

  task automatic test_no_filter();
    rise_mask = 4'b1000;
    pad_i[3] = 1'b1;
    step(1);
    pad_i[3] = 1'b0;
    step(1);
    vectors++;
    if (in_data[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL nf_early got %b want 0", in_data[3]);
    end
    step(1);
    vectors++;
    if (in_data[3] !== 1'b1 || irq_status !== 4'b1000) begin
      miscompares++;
      $display("FAIL nf_pulse got %b/%b want 1/1000", in_data[3], irq_status);
    end
    step(1);
    vectors++;
    if (in_data[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL nf_drop got %b want 0", in_data[3]);
    end
    rise_mask = '0;
    clear_all();
  endtask

  initial begin
    rst = 1'b1;
    pad_i = '0;
    mode = '0;
    out_data = '0;
    rise_mask = '0;
    fall_mask = '0;
    irq_clr = '0;
    step(2);
    rst = 1'b0;
    test_reset();
    test_drive_modes();
`ifdef BOARD_IO_BANK_DEBOUNCE_EN
    test_glitch();
`else
    test_no_filter();
`endif
    test_fall_mask();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
